// File: rtl/cam_config_if.sv
// Bus bundle for the camera configuration sequencer: start/status, config ROM port
// and the register-write request channel toward the SCCB master.
interface cam_config_if;
    logic        i_start;
    logic [7:0]  o_rom_addr;
    logic [15:0] i_rom_data;
    logic        o_sccb_valid;
    logic [7:0]  o_sccb_addr;
    logic [7:0]  o_sccb_data;
    logic        i_sccb_ready;
    logic        o_busy;
    logic        o_done;

    modport master (
        input  i_start, i_rom_data, i_sccb_ready,
        output o_rom_addr, o_sccb_valid, o_sccb_addr, o_sccb_data, o_busy, o_done
    );

    modport slave (
        output i_start, i_rom_data, i_sccb_ready,
        input  o_rom_addr, o_sccb_valid, o_sccb_addr, o_sccb_data, o_busy, o_done
    );
endinterface

// File: rtl/cam_config.sv
// Walks a synchronous config ROM and issues OV7670 register writes, honouring
// FFF0 delay markers and an FFFF end marker.
//
// state  | meaning
// IDLE   | waiting for i_start after reset
// FETCH  | ROM address presented, waiting one cycle for read data
// DECODE | classify ROM word: end marker, delay marker or register write
// SEND   | write request held until the SCCB master accepts it
// DELAY  | counting down DELAY_CYCLES before the next entry
// DONE   | pass finished; sticky until the next i_start
module cam_config #(
    parameter int unsigned DELAY_CYCLES = 1_000_000
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    cam_config_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, DELAY, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  rom_addr_q;
    logic        valid_q;
    logic [7:0]  sccb_addr_q;
    logic [7:0]  sccb_data_q;
    logic [23:0] cnt_q;
    logic        busy_q;
    logic        done_q;

    logic advance;
    logic last_entry;

    assign advance    = ((state_q == SEND) && bus.i_sccb_ready) ||
                        ((state_q == DELAY) && (cnt_q == 24'd0));
    assign last_entry = (rom_addr_q == 8'hFF);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.i_start) state_d = FETCH;
            FETCH:      state_d = DECODE;
            DECODE: begin
                if (bus.i_rom_data == 16'hFFFF)      state_d = DONE;
                else if (bus.i_rom_data == 16'hFFF0) state_d = DELAY;
                else                                 state_d = SEND;
            end
            SEND, DELAY: if (advance) state_d = last_entry ? DONE : FETCH;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            rom_addr_q  <= 8'd0;
            valid_q     <= 1'b0;
            sccb_addr_q <= 8'd0;
            sccb_data_q <= 8'd0;
            cnt_q       <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE) && (state_d != DONE);
            done_q  <= (state_d == DONE);

            if (((state_q == IDLE) || (state_q == DONE)) && bus.i_start)
                rom_addr_q <= 8'd0;
            // The address never wraps: the last entry ends the pass at 255.
            else if (advance && !last_entry)
                rom_addr_q <= rom_addr_q + 8'd1;

            if (state_q == DECODE && state_d == SEND) begin
                sccb_addr_q <= bus.i_rom_data[15:8];
                sccb_data_q <= bus.i_rom_data[7:0];
                valid_q     <= 1'b1;
            end else if (state_q == SEND && bus.i_sccb_ready) begin
                valid_q <= 1'b0;
            end

            if (state_q == DECODE && state_d == DELAY)
                cnt_q <= 24'(DELAY_CYCLES - 1);
            else if (state_q == DELAY && cnt_q != 24'd0)
                cnt_q <= cnt_q - 24'd1;
        end
    end

    assign bus.o_rom_addr   = rom_addr_q;
    assign bus.o_sccb_valid = valid_q;
    assign bus.o_sccb_addr  = sccb_addr_q;
    assign bus.o_sccb_data  = sccb_data_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
endmodule

// File: tb/tb_cam_config.sv
// Scoreboard bench for cam_config: a ROM-walk reference model queues expected writes,
// a monitor pops and compares every accepted SCCB request.
module tb_cam_config;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cam_config_if bus();
    cam_config #(.DELAY_CYCLES(D)) dut (.i_clk(clk), .i_rstn(rst_n), .bus(bus));

    logic [15:0] rom [256];
    always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_addr];

    typedef struct { logic [15:0] w; int gap; } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int cyc = 0;
    int last_x = -1;
    int final_addr = 0;
    bit gap_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the ROM by the rules, listing expected writes and the
    // cycle gap between consecutive accepted writes when ready is always high.
    task automatic build_expect();
        bit first = 1'b1;
        int g = 0;
        exp_q.delete();
        final_addr = 255;
        for (int a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) begin
                final_addr = a;
                return;
            end else if (rom[a] == 16'hFFF0) begin
                if (!first) g += D + 2;
            end else begin
                exp_q.push_back('{rom[a], first ? -1 : g});
                first = 1'b0;
                g = 3;
            end
        end
    endtask

    initial begin
        bus.i_sccb_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.i_sccb_ready = 1'b1;
                1:       bus.i_sccb_ready = ($urandom_range(0, 3) != 0);
                default: bus.i_sccb_ready = 1'b0;
            endcase
        end
    end

    logic       pv_stall = 1'b0;
    logic [7:0] pa, pd;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n === 1'b1) begin
            if (pv_stall) begin
                check("hold_valid", 32'(bus.o_sccb_valid), 32'd1);
                check("hold_addr_data", 32'({bus.o_sccb_addr, bus.o_sccb_data}), 32'({pa, pd}));
            end
            if (bus.o_sccb_valid && bus.i_sccb_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got %02h_%02h expected none",
                             bus.o_sccb_addr, bus.o_sccb_data);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer", 32'({bus.o_sccb_addr, bus.o_sccb_data}), 32'(e.w));
                    if (gap_en && e.gap > 0 && last_x >= 0)
                        check("xfer_gap", 32'(cyc - last_x), 32'(e.gap));
                end
                last_x = cyc;
            end
            pv_stall = bus.o_sccb_valid && !bus.i_sccb_ready;
            pa = bus.o_sccb_addr;
            pd = bus.o_sccb_data;
        end else begin
            pv_stall = 1'b0;
        end
    end

    task automatic start_pass();
        build_expect();
        last_x = -1;
        @(posedge clk);
        #1 bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
    endtask

    task automatic finish_pass(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.o_done) break;
        end
        if (i == budget) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no o_done expected o_done within %0d cycles", budget);
        end
        check("done", 32'(bus.o_done), 32'd1);
        check("busy_at_done", 32'(bus.o_busy), 32'd0);
        check("valid_at_done", 32'(bus.o_sccb_valid), 32'd0);
        check("final_addr", 32'(bus.o_rom_addr), 32'(final_addr));
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fill_basic();
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1204;
        rom[3] = 16'hFFFF;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rom_addr"}, 32'(bus.o_rom_addr), 32'd0);
        check({tag, "_valid"}, 32'(bus.o_sccb_valid), 32'd0);
        check({tag, "_addr_data"}, 32'({bus.o_sccb_addr, bus.o_sccb_data}), 32'd0);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
    endtask

    initial begin
        int i;
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        fill_basic();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic ROM: two writes, 16-cycle delay between them.
        gap_en = 1'b1;
        ready_mode = 0;
        start_pass();
        finish_pass(500);

        // Stall the first write for 50 cycles; a start pulse in SEND must be ignored.
        ready_mode = 2;
        start_pass();
        for (i = 0; i < 100 && !bus.o_sccb_valid; i++) @(negedge clk);
        if (i == 100) begin
            checks++;
            errors++;
            $display("FAIL stall_valid_timeout: got valid=0 expected valid=1");
        end
        for (int k = 0; k < 50; k++) begin
            check("stall_req", 32'({bus.o_sccb_valid, bus.o_sccb_addr, bus.o_sccb_data}), 32'h11280);
            bus.i_start = (k == 20);
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        ready_mode = 0;
        finish_pass(500);

        // Restart from DONE: an identical second pass.
        start_pass();
        finish_pass(500);

        // 76-entry register table with one delay marker, random ready.
        gap_en = 1'b0;
        ready_mode = 1;
        for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
        for (int a = 0; a < 76; a++)
            rom[a] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
        rom[10] = 16'hFFF0;
        start_pass();
        finish_pass(3000);
        check("table_final_addr", 32'(bus.o_rom_addr), 32'd76);

        // No end marker: 256 writes, address stops at 255.
        gap_en = 1'b1;
        ready_mode = 0;
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        start_pass();
        finish_pass(2000);

        // Random ROM contents and random ready.
        gap_en = 1'b0;
        ready_mode = 1;
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < 256; a++) begin
                case ($urandom_range(0, 19))
                    0:       rom[a] = 16'hFFF0;
                    default: rom[a] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
                endcase
                if (rom[a] == 16'hFFFF) rom[a] = 16'h0000;
            end
            if (p != 3) rom[$urandom_range(1, 255)] = 16'hFFFF;
            start_pass();
            finish_pass(12000);
        end

        // Asynchronous reset in the middle of a delay (counter at 5).
        gap_en = 1'b1;
        ready_mode = 0;
        fill_basic();
        start_pass();
        for (i = 0; i < 100 && bus.o_rom_addr != 8'd1; i++) @(negedge clk);
        if (i == 100) begin
            checks++;
            errors++;
            $display("FAIL delay_entry_timeout: got rom_addr=%0d expected 1", bus.o_rom_addr);
        end
        repeat (12) @(negedge clk);
        check("in_delay_busy", 32'({bus.o_busy, bus.o_sccb_valid}), 32'b10);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", 32'({bus.o_busy, bus.o_rom_addr}), 32'd0);
        start_pass();
        finish_pass(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cam_config.md
CAM_CONFIG -- requirements
Module: cam_config

Interface
REQ-001 Parameter DELAY_CYCLES, default 1_000_000, clock cycles spent on a delay marker (10 ms at 100 MHz); legal range 1..2^24-1.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rstn  in  1  reset, asynchronous, active-low.
REQ-004 i_start  in  1  single-cycle pulse; begins a configuration pass.
REQ-005 o_rom_addr  out  8  address to the synchronous config ROM.
REQ-006 i_rom_data  in  16  ROM word {reg_addr[15:8], reg_data[7:0]}, valid one cycle after o_rom_addr changes.
REQ-007 o_sccb_valid  out  1  register-write request to SCCB master.
REQ-008 o_sccb_addr  out  8  OV7670 register address for the request.
REQ-009 o_sccb_data  out  8  OV7670 register data for the request.
REQ-010 i_sccb_ready  in  1  SCCB master can accept a request this cycle.
REQ-011 o_busy  out  1  high in every state except IDLE and DONE.
REQ-012 o_done  out  1  high while in DONE.

Function
REQ-013 States: IDLE, FETCH, DECODE, SEND, DELAY, DONE; state register is the only source of o_busy/o_done (registered, no combinational path from inputs).
REQ-014 IDLE: on i_start=1, o_rom_addr<=0, go FETCH; otherwise hold.
REQ-015 FETCH: one-cycle wait for ROM latency, unconditionally go DECODE.
REQ-016 DECODE, i_rom_data==16'hFFFF: go DONE (end marker; no write issued).
REQ-017 DECODE, i_rom_data==16'hFFF0: load delay counter with DELAY_CYCLES-1, go DELAY (no write issued).
REQ-018 DECODE, any other word: latch o_sccb_addr<=i_rom_data[15:8], o_sccb_data<=i_rom_data[7:0], assert o_sccb_valid, go SEND.
REQ-019 SEND: o_sccb_valid, o_sccb_addr, o_sccb_data held stable until the cycle where o_sccb_valid&i_sccb_ready=1; that cycle is the transfer.
REQ-020 On transfer: o_sccb_valid<=0 next cycle, o_rom_addr increments, go FETCH; exactly one transfer per ROM entry.
REQ-021 DELAY: counter decrements each cycle; in the cycle counter==0, o_rom_addr increments, go FETCH; DELAY occupies exactly DELAY_CYCLES cycles.
REQ-022 Address wrap: if an increment would take o_rom_addr from 255 to 0, go DONE instead of FETCH; o_rom_addr stays 255.
REQ-023 i_start ignored while o_busy=1.
REQ-024 DONE: sticky until i_start=1, which restarts a full pass exactly as from IDLE (o_rom_addr<=0, go FETCH).
REQ-025 i_rom_data sampled only in DECODE; changes in other states have no effect.
REQ-026 i_sccb_ready sampled only in SEND; ready without valid has no effect.

Reset
REQ-027 i_rstn=0 forces, asynchronously: state=IDLE, o_rom_addr=0, o_sccb_valid=0, o_sccb_addr=0, o_sccb_data=0, delay counter=0, o_busy=0, o_done=0.
REQ-028 Reset mid-operation (including during SEND with valid high or during DELAY) abandons the pass; after release the block waits in IDLE for a new i_start.

Verification
REQ-029 ROM model {0:12_80, 1:FF_F0, 2:12_04, 3:FF_FF}, DELAY_CYCLES=16, ready always 1, pulse i_start -> transfers (12,80) then (12,04) only; 16 cycles between DELAY entry and fetch of addr 2; o_done=1 after addr 3 decode.
REQ-030 Same ROM, i_sccb_ready held 0 for 50 cycles in first SEND -> o_sccb_valid/addr/data stable (1,12,80) all 50 cycles; one transfer when ready rises.
REQ-031 Full 76-entry OV7670 table plus FFFF at 76, with 1 marker -> exactly 75 transfers in ROM order, one delay, o_done=1, o_rom_addr=76.
REQ-032 ROM all entries 16'h0000 (no end marker) -> 256 transfers, then DONE with o_rom_addr=255, no wrap to 0.
REQ-033 Assert i_rstn=0 during DELAY counter=5 -> all outputs 0 immediately (before next edge); i_start after release restarts at addr 0.
REQ-034 i_start pulsed during SEND -> ignored; pulsed in DONE -> second complete pass identical to first.
